// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode stage: FSM states, instruction field positions, special words.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_decode_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fsm_state_e;

  // Instruction field bit positions
  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JADDR_HI = 25;
  localparam int JADDR_LO = 0;

  localparam logic [31:0] NOP_WORD          = 32'd0;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_decode_stage_if_id_reg.sv
// IF/ID pipeline register: enable-gated capture, synchronous flush to zero, async active-low reset.
// Latency: 1 cycle from d_i to q_o when en_i=1.
// Backpressure: en_i=0 holds contents; flush_i wins over en_i and loads all-zero (bubble).
module fetch_decode_stage_if_id_reg #(
  parameter int W = 65
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Pipeline register: flush beats capture, otherwise hold
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q <= '0;
    end else if (flush_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// IF + IF/ID stage: PC register, fetch FSM (BOOT/RUN/HALT), IF/ID capture and field split.
// Latency: fetched word appears on instr_id/fields 1 cycle after its PC is on imem_addr.
// Backpressure: load_stall=0 holds PC and IF/ID; redirect flushes one bubble. FETCH_PERF_CNT_EN adds stall/flush counters.
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] PC_INC    = 32'd1,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
`ifdef FETCH_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic        valid_id,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [25:0] jaddr,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  fsm_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ifid_en, ifid_flush;
  logic [64:0] ifid_d, ifid_q;
  logic [31:0] instr_q, pcid_q;
  logic        valid_q;
  logic [31:0] fld_word;

  // IF/ID payload is {instr, pc, valid}; a flush zeroes all three (NOP bubble)
  assign ifid_d = {imem_data, pc_q, 1'b1};
  assign {instr_q, pcid_q, valid_q} = ifid_q;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // PC register (register32 style with async active-low reset)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // Next state, next PC and IF/ID control; redirect > halt detect > advance > hold
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
        end else if (valid_q && (instr_q == HALT_WORD) && load_stall) begin
          state_d = ST_HALT;
        end else if (load_stall) begin
          ifid_en = 1'b1;
          pc_d    = pc_q + PC_INC;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  fetch_decode_stage_if_id_reg #(.W(65)) u_if_id_reg (
    .clk_i   (clk),
    .rst_n_i (reset),
    .en_i    (ifid_en),
    .flush_i (ifid_flush),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign imem_addr = pc_q;
  assign instr_id  = instr_q;
  assign pc_id     = pcid_q;
  assign halted    = (state_q == ST_HALT);
  // The halt word stays in IF/ID while halted but must never look valid downstream
  assign valid_id  = valid_q && (state_q != ST_HALT);

  // Fields read as zero for bubbles so control never decodes stale bits
  assign fld_word = valid_id ? instr_q : NOP_WORD;
  assign opcode   = fld_word[OPC_HI:OPC_LO];
  assign rs       = fld_word[RS_HI:RS_LO];
  assign rt       = fld_word[RT_HI:RT_LO];
  assign rd       = fld_word[RD_HI:RD_LO];
  assign funct    = fld_word[FUNCT_HI:FUNCT_LO];
  assign imm      = fld_word[IMM_HI:IMM_LO];
  assign jaddr    = fld_word[JADDR_HI:JADDR_LO];

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             in_run;

  assign in_run = (state_q == ST_RUN);

  // Saturating counters of RUN-state stall and redirect cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (in_run && !redirect && !load_stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (in_run && redirect && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: directed scenarios followed by random stall/redirect/reset traffic.
// Latency: expected state pushed at the driving negedge, checked 2 time units after the next rising edge.
// Backpressure: load_stall/redirect randomised; imem modelled as a combinational array read.
module tb_fetch_decode_stage;

  localparam int MB = 0;  // boot
  localparam int MR = 1;  // run
  localparam int MH = 2;  // halt
  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_data;
  logic [31:0] imem_addr, instr_id, pc_id;
  logic        valid_id, halted;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] jaddr;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  logic [31:0] mem [0:63];
  assign imem_data = mem[imem_addr[5:0]];

  always #5 clk = ~clk;

  fetch_decode_stage dut (
    .clk(clk), .reset(reset), .load_stall(load_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_data(imem_data), .imem_addr(imem_addr),
    .instr_id(instr_id), .pc_id(pc_id), .valid_id(valid_id), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .jaddr(jaddr),
    .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc_if, instr, pc_id, word;
    logic        valid, halted;
    int          nstall, nflush;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pcid;
  logic        m_valid;
  int          m_mode, m_stall, m_flush;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the architectural behaviour, then push what the outputs must show afterwards
  task automatic cyc(input logic r, input logic ld, input logic rdr, input logic [31:0] rpc);
    exp_t e;
    logic [31:0] fetched;
    @(negedge clk);
    reset = r; load_stall = ld; redirect = rdr; redirect_pc = rpc;
    fetched = mem[m_pc[5:0]];
    if (!r) begin
      m_pc = 32'd0; m_instr = 32'd0; m_pcid = 32'd0; m_valid = 1'b0;
      m_mode = MB; m_stall = 0; m_flush = 0;
    end else if (m_mode == MB) begin
      m_mode = MR;
    end else if (m_mode == MR) begin
      if (rdr) begin
        m_pc = rpc; m_instr = 32'd0; m_pcid = 32'd0; m_valid = 1'b0;
        if (m_flush < 65535) m_flush++;
      end else if (m_valid && m_instr == HW && ld) begin
        m_mode = MH;
      end else if (ld) begin
        m_pcid = m_pc; m_instr = fetched; m_valid = 1'b1; m_pc = m_pc + 32'd1;
      end else begin
        if (m_stall < 65535) m_stall++;
      end
    end
    e.pc_if  = m_pc;
    e.instr  = m_instr;
    e.pc_id  = m_pcid;
    e.valid  = m_valid && (m_mode != MH);
    e.halted = (m_mode == MH);
    e.word   = e.valid ? m_instr : 32'd0;
    e.nstall = m_stall;
    e.nflush = m_flush;
    q.push_back(e);
  endtask

  // Monitor: every cycle the stage presents a full set of outputs; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_if",    imem_addr, e.pc_if);
        chk("instr_id", instr_id,  e.instr);
        chk("pc_id",    pc_id,     e.pc_id);
        chk("valid_id", 32'(valid_id), 32'(e.valid));
        chk("halted",   32'(halted),   32'(e.halted));
        chk("opcode",   32'(opcode), 32'(e.word[31:26]));
        chk("rs",       32'(rs),     32'(e.word[25:21]));
        chk("rt",       32'(rt),     32'(e.word[20:16]));
        chk("rd",       32'(rd),     32'(e.word[15:11]));
        chk("funct",    32'(funct),  32'(e.word[5:0]));
        chk("imm",      32'(imm),    32'(e.word[15:0]));
        chk("jaddr",    32'(jaddr),  32'(e.word[25:0]));
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), e.nstall);
        chk("flush_cnt", 32'(flush_cnt), e.nflush);
`endif
      end
    end
  end

  task automatic mem_ramp();
    for (int i = 0; i < 64; i++) mem[i] = 32'h100 + i;
  endtask

  initial begin
    int sel;
    logic [31:0] rpc;
    m_pc = 0; m_instr = 0; m_pcid = 0; m_valid = 0; m_mode = MB; m_stall = 0; m_flush = 0;
    mem_ramp();
    mem[2] = 32'h0022_1820;

    // Reset, boot, fetch 0..2, stall 3 on the add, redirect while stalled, resume
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 32'h40);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    // PC wrap
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    // Reset mid-stall
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);

    // Halt word at pc 5, redirect ignored while halted, then reset out
    mem_ramp();
    mem[5] = HW;
    repeat (10) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 32'h20);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);

    // Halt word fetched in the shadow of a redirect is flushed
    repeat (7) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 32'h10);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 32'd0);

    // Random traffic with occasional halt words and resets
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 11) == 0) ? HW : $urandom;
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 3);
      rpc = (sel == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1))) : 32'($urandom_range(0, 63));
      cyc(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
          ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
          rpc);
    end

    // Drain the scoreboard with a bounded wait
    repeat (4) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- IF and IF/ID stage that sits directly upstream of the pipelined datapath.
- Holds the PC and drives the instruction-memory address.
- Captures each fetched word and its PC into the IF/ID register, then splits it into the fields the datapath and control consume: rs, rt, rd, imm, opcode, funct, jump target and PC.
- Handles stall (hold), redirect (branch/jump/jr flush) and a halt state machine.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- PC_INC, 32'd1, PC increment per fetch. Word-addressed: the datapath links PC+1.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  input  1  Rising-edge clock.
- reset  input  1  Asynchronous, active-low reset.
- load_stall  input  1  Pipeline register enable, same sense as the datapath: 1 = advance, 0 = hold.
- redirect  input  1  Taken branch, j, jal or jr resolved downstream. Flushes IF/ID.
- redirect_pc  input  32  Target PC when redirect=1.
- imem_data  input  32  Instruction word; combinational read of imem_addr.
- imem_addr  output  32  Current fetch PC (pc_if).
- instr_id  output  32  Instruction held in IF/ID.
- pc_id  output  32  PC of instr_id.
- valid_id  output  1  instr_id is a real instruction, not a bubble.
- opcode  output  6  instr_id[31:26]
- rs  output  5  instr_id[25:21]
- rt  output  5  instr_id[20:16]
- rd  output  5  instr_id[15:11]
- funct  output  6  instr_id[5:0]
- imm  output  16  instr_id[15:0]
- jaddr  output  26  instr_id[25:0]
- halted  output  1  FSM is in HALT.

Behaviour:
- Async reset (reset=0):
  - pc_if=RESET_PC.
  - instr_id=32'd0 (NOP); pc_id=0; valid_id=0.
  - FSM=BOOT; halted=0.
- Field outputs are pure slices of instr_id. When valid_id=0 they all read 0.
- FSM states:
  - BOOT: one cycle after reset release. No fetch; PC and IF/ID hold. Go to RUN unconditionally. This gives imem one settle cycle.
  - RUN: normal fetch, per the priority rules below.
  - HALT: pc_if and IF/ID frozen; valid_id forced 0; halted=1. Exit only via reset. redirect is ignored in HALT.
- RUN priority per rising edge (evaluate top to bottom):
  1. redirect=1, regardless of load_stall: pc_if<=redirect_pc; instr_id<=0; valid_id<=0; pc_id<=0.
  2. Else if valid_id=1, instr_id==HALT_WORD and load_stall=1: go to HALT. The halt word is never passed on as valid.
  3. Else if load_stall=1: instr_id<=imem_data; pc_id<=pc_if; valid_id<=1; pc_if<=pc_if+PC_INC.
  4. Else (load_stall=0): hold pc_if and all IF/ID state.
- Latency: a word fetched at pc_if appears on instr_id and the field outputs 1 cycle later.
- A redirect costs exactly 1 bubble.
- PC arithmetic is 32-bit unsigned and wraps mod 2^32 (32'hFFFFFFFF+1 = 0). No overflow flag.
- A halt word fetched in the shadow of a redirect is flushed and never halts.
- Reset asserted mid-stall or mid-halt overrides everything immediately (asynchronous).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
  - stall_cnt increments on each RUN cycle with load_stall=0 and redirect=0.
  - flush_cnt increments on each RUN cycle with redirect=1.
  - Both saturate at all-ones, reset to 0, and are frozen in BOOT and HALT.
- When not defined: the ports and logic are absent. Core behaviour is identical either way.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
  - Instruction field bit positions (OPC_HI/LO, RS_HI/LO, RT, RD, FUNCT, IMM, JADDR).
  - NOP encoding 32'd0 and the default HALT_WORD.
- One natural sub-module: if_id_reg. It is the IF/ID pipeline register with enable, synchronous flush and async active-low reset, and is reusable for the later ID/EX split.
- The PC register reuses the existing register32 style, with an async active-low reset variant.

Test Plan:
- Reset release, load_stall=1, imem returns addr+32'h100: cycle 1 is BOOT with pc_if=0; then pc_id=0/instr_id=32'h100, pc_id=1/instr_id=32'h101, with valid_id=1 and pc_if incrementing by 1.
- load_stall=0 for 3 cycles with instr_id=32'h00221820 (add rd=3): pc_if, instr_id, valid_id unchanged; rs=1, rt=2, rd=3, funct=6'h20 held stable.
- redirect=1, redirect_pc=32'h40 while load_stall=0: next edge gives pc_if=32'h40, valid_id=0, instr_id=0; following edge gives pc_id=32'h40.
- imem returns HALT_WORD at pc 5 with no redirect: HALT_WORD sits in IF/ID with valid_id=1; on the next advancing edge halted=1, valid_id=0, pc_if frozen at 6 permanently. Asserting reset returns pc_if=0 and FSM to BOOT.
- HALT_WORD at pc 5 with redirect=1 to 32'h10 on the edge after it is fetched: halt word is flushed, halted stays 0, fetch continues at 32'h10.
- FETCH_PERF_CNT_EN, CNT_W=4: 20 stall cycles give stall_cnt=4'hF (saturated); 2 redirects give flush_cnt=2.
